// File: rtl/decoder_pulse_seq.sv
// decoder_pulse_seq: handshaked N-to-OUT_W decoder that holds a one-hot/thermometer pattern for HOLD cycles, then idles GAP cycles
module decoder_pulse_seq #(
  parameter int N = 4,
  parameter int OUT_W = 16,
  parameter int HOLD = 4,
  parameter int GAP = 1,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_code,
  input  logic [1:0]       in_mode,
  input  logic             in_en,
  input  logic             flush,
  output logic [OUT_W-1:0] out,
  output logic             out_valid,
  output logic             busy,
  output logic             err
);
  localparam int MX = HOLD > GAP ? HOLD : GAP;
  localparam int CW = $clog2(MX + 1);
  localparam logic [OUT_W-1:0] INACT = {OUT_W{ACTIVE_LOW}};
  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_GAP} state_t;
  state_t r_state, w_nstate;
  logic [CW-1:0] r_cnt, w_ncnt;
  logic [OUT_W-1:0] r_out, w_nout, w_one, w_pat;
  logic r_err, w_nerr, w_acc, w_bad;
  always_comb begin
    w_acc = in_valid && r_state == S_IDLE;
    w_bad = 32'(in_code) >= OUT_W || in_mode == 2'b11;
    w_one = OUT_W'(1) << in_code;
    w_pat = INACT ^ (in_mode == 2'b00 ? w_one :
                     in_mode == 2'b01 ? (w_one << 1) - OUT_W'(1) : ~(w_one - OUT_W'(1)));
    w_nerr = w_acc && in_en && w_bad;
    w_nstate = r_state;
    w_ncnt = r_cnt;
    w_nout = r_out;
    if (r_state == S_IDLE) begin
      if (w_acc && in_en && !w_bad) begin
        w_nstate = S_ACTIVE;
        w_ncnt = CW'(HOLD - 1);
        w_nout = w_pat;
      end
    end else if (flush) begin
      w_nstate = S_IDLE;
      w_ncnt = '0;
      w_nout = INACT;
    end else if (r_cnt != '0) begin
      w_ncnt = r_cnt - CW'(1);
    end else if (r_state == S_ACTIVE && GAP > 0) begin
      w_nstate = S_GAP;
      w_ncnt = CW'(GAP - 1);
      w_nout = INACT;
    end else begin
      w_nstate = S_IDLE;
      w_nout = INACT;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt <= '0;
      r_out <= INACT;
      r_err <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_cnt <= w_ncnt;
      r_out <= w_nout;
      r_err <= w_nerr;
    end
  end
  assign in_ready = r_state == S_IDLE;
  assign out = r_out;
  assign out_valid = r_state == S_ACTIVE;
  assign busy = r_state != S_IDLE;
  assign err = r_err;
endmodule
